// File: rtl/ym_write_scheduler.sv
// Purpose: round-robin arbiter that turns {port, reg, data} requests into YM2612 address/data bus writes.
// Latency: ack and address phase one cycle after req is sampled in IDLE; 1+2*WR_PULSE+GAP+SETTLE+1 cycles minimum per write.
// Backpressure: requests are only taken in IDLE; requesters hold req with payload until ack, later reqs wait for busy to fall.
module ym_write_scheduler #(
    parameter int WR_PULSE = 12,
    parameter int GAP      = 12,
    parameter int SETTLE   = 12,
    parameter int TIMEOUT  = 4096
) (
    input  logic       clk50,
    input  logic       rst,
    input  logic       req0,
    input  logic       port0,
    input  logic [7:0] reg0,
    input  logic [7:0] dat0,
    output logic       ack0,
    input  logic       req1,
    input  logic       port1,
    input  logic [7:0] reg1,
    input  logic [7:0] dat1,
    output logic       ack1,
    output logic [7:0] ym_din,
    output logic [1:0] ym_addr,
    output logic       ym_cs_n,
    output logic       ym_wr_n,
    input  logic [7:0] ym_dout,
    output logic       busy,
    output logic       grant_id,
    output logic       timeout,
    input  logic       err_clr
);

    localparam int MAX_AB  = (WR_PULSE > GAP) ? WR_PULSE : GAP;
    localparam int MAX_CD  = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADR_WR,
        ADR_GAP,
        DAT_WR,
        DAT_SETTLE,
        BUSY_WAIT
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           lat_port;
    logic [7:0]     lat_dat;
    logic           last_grant;

    logic           sel1;
    logic           sel_port;
    logic [7:0]     sel_reg;
    logic [7:0]     sel_dat;

    // Only dout[7] (busy) carries meaning for this block.
    logic           unused_dout;
    assign unused_dout = ^ym_dout[6:0];

    // Winner select: a lone requester wins; on a tie the one that did not win last time goes.
    always_comb begin
        sel1     = req1 && (!req0 || !last_grant);
        sel_port = sel1 ? port1 : port0;
        sel_reg  = sel1 ? reg1  : reg0;
        sel_dat  = sel1 ? dat1  : dat0;
    end

    // Sequencer: one shared down-counter times every phase and is reloaded on each state entry.
    always_ff @(posedge clk50) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_port   <= 1'b0;
            lat_dat    <= 8'h00;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            ym_din     <= 8'h00;
            ym_addr    <= 2'b00;
            ym_cs_n    <= 1'b1;
            ym_wr_n    <= 1'b1;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (err_clr) begin
                timeout <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        lat_port   <= sel_port;
                        lat_dat    <= sel_dat;
                        grant_id   <= sel1;
                        last_grant <= sel1;
                        ack0       <= !sel1;
                        ack1       <= sel1;
                        busy       <= 1'b1;
                        ym_addr    <= {sel_port, 1'b0};
                        ym_din     <= sel_reg;
                        ym_cs_n    <= 1'b0;
                        ym_wr_n    <= 1'b0;
                        cnt        <= CW'(WR_PULSE - 1);
                        state      <= ADR_WR;
                    end
                end
                ADR_WR: begin
                    if (cnt == '0) begin
                        ym_cs_n <= 1'b1;
                        ym_wr_n <= 1'b1;
                        cnt     <= CW'(GAP - 1);
                        state   <= ADR_GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ADR_GAP: begin
                    if (cnt == '0) begin
                        ym_addr <= {lat_port, 1'b1};
                        ym_din  <= lat_dat;
                        ym_cs_n <= 1'b0;
                        ym_wr_n <= 1'b0;
                        cnt     <= CW'(WR_PULSE - 1);
                        state   <= DAT_WR;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DAT_WR: begin
                    if (cnt == '0) begin
                        ym_cs_n <= 1'b1;
                        ym_wr_n <= 1'b1;
                        cnt     <= CW'(SETTLE - 1);
                        state   <= DAT_SETTLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DAT_SETTLE: begin
                    if (cnt == '0) begin
                        cnt   <= CW'(TIMEOUT - 1);
                        state <= BUSY_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BUSY_WAIT: begin
                    // The write counts as done either way; a stuck busy flag is only reported.
                    if (!ym_dout[7]) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    ym_cs_n <= 1'b1;
                    ym_wr_n <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
